// File: rtl/hazard_fwd_pkg.sv
// Shared constants for the decode-side hazard/forwarding unit.
package hazard_fwd_pkg;

  localparam int unsigned REG_BITS = 3;

  // RegSrc encoding whose selection of the memory read data marks an LD.
  localparam logic [1:0] REGSRC_MEM = 2'b01;

  function automatic logic is_load_sel(input logic [1:0] reg_src);
    return reg_src == REGSRC_MEM;
  endfunction

endpackage

// File: rtl/hazard_fwd_unit_shadow.sv
// One shadow pipeline slot (valid + destination + load flag) with
// async active-low clear, hold, and bubble insertion.
module hazard_shadow_stage #(
  parameter int unsigned W = 3
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         hold_i,
  input  logic         bubble_i,
  input  logic         v_i,
  input  logic [W-1:0] reg_i,
  input  logic         ld_i,
  output logic         v_o,
  output logic [W-1:0] reg_o,
  output logic         ld_o
);

  logic         v_q, v_d;
  logic [W-1:0] reg_q, reg_d;
  logic         ld_q, ld_d;

  // A bubble only kills valid/load; the stale register field is harmless.
  always_comb begin
    v_d   = v_q;
    reg_d = reg_q;
    ld_d  = ld_q;
    if (!hold_i) begin
      if (bubble_i) begin
        v_d  = 1'b0;
        ld_d = 1'b0;
      end else begin
        v_d   = v_i;
        reg_d = reg_i;
        ld_d  = ld_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v_q   <= 1'b0;
      reg_q <= '0;
      ld_q  <= 1'b0;
    end else begin
      v_q   <= v_d;
      reg_q <= reg_d;
      ld_q  <= ld_d;
    end
  end

  assign v_o   = v_q;
  assign reg_o = reg_q;
  assign ld_o  = ld_q;

endmodule

// File: rtl/hazard_fwd_unit.sv
// Decode-side forwarding flags, load-use stall and ID/EX bubble control,
// driven by a two-slot shadow of in-flight destinations (EX, MEM).
module hazard_fwd_unit import hazard_fwd_pkg::*; #(
  parameter int unsigned CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [REG_BITS-1:0] src1,
  input  logic [REG_BITS-1:0] src2,
  input  logic                uses1,
  input  logic                uses2,
  input  logic                RegWrt_D,
  input  logic [REG_BITS-1:0] write_reg_D,
  input  logic                is_load_D,
  input  logic                flush,
  input  logic                freeze,
  output logic                EXFWD1_D,
  output logic                EXFWD2_D,
  output logic                MEMFWD1_D,
  output logic                MEMFWD2_D,
  output logic                stall,
  output logic                SendNOP_In,
  output logic [CNT_W-1:0]    stall_count
);

  logic                ex_v, ex_ld;
  logic [REG_BITS-1:0] ex_reg;
  logic                mem_v, mem_ld_unused;
  logic [REG_BITS-1:0] mem_reg;

  hazard_shadow_stage #(.W(REG_BITS)) u_ex (
    .clk_i    (clk),
    .rst_ni   (rst),
    .hold_i   (freeze),
    .bubble_i (SendNOP_In),
    .v_i      (RegWrt_D),
    .reg_i    (write_reg_D),
    .ld_i     (is_load_D),
    .v_o      (ex_v),
    .reg_o    (ex_reg),
    .ld_o     (ex_ld)
  );

  // MEM only needs valid+reg; its load flag is never consulted.
  hazard_shadow_stage #(.W(REG_BITS)) u_mem (
    .clk_i    (clk),
    .rst_ni   (rst),
    .hold_i   (freeze),
    .bubble_i (1'b0),
    .v_i      (ex_v),
    .reg_i    (ex_reg),
    .ld_i     (1'b0),
    .v_o      (mem_v),
    .reg_o    (mem_reg),
    .ld_o     (mem_ld_unused)
  );

  logic exm1, exm2, memm1, memm2, lu;

  assign exm1  = uses1 & ex_v  & (ex_reg  == src1);
  assign exm2  = uses2 & ex_v  & (ex_reg  == src2);
  assign memm1 = uses1 & mem_v & (mem_reg == src1);
  assign memm2 = uses2 & mem_v & (mem_reg == src2);
  assign lu    = (exm1 | exm2) & ex_ld;

  // Flush overrides a load-use: the squashed instruction needs no stall.
  assign stall      = lu & ~flush;
  assign SendNOP_In = lu | flush;
  assign EXFWD1_D   = exm1 & ~ex_ld & ~SendNOP_In;
  assign EXFWD2_D   = exm2 & ~ex_ld & ~SendNOP_In;
  assign MEMFWD1_D  = memm1 & ~exm1 & ~SendNOP_In;
  assign MEMFWD2_D  = memm2 & ~exm2 & ~SendNOP_In;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!freeze && stall && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign stall_count = cnt_q;

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Randomised + directed scoreboard bench for hazard_fwd_unit; a second
// instance with a 4-bit counter exercises saturation cheaply.
module tb_hazard_fwd_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] src1, src2, write_reg_D;
  logic       uses1, uses2, RegWrt_D, is_load_D, flush, freeze;
  logic       exf1, exf2, mf1, mf2, stall, nop;
  logic [15:0] cnt;
  logic       exf1_s, exf2_s, mf1_s, mf2_s, stall_s, nop_s;
  logic [3:0] cnt_s;

  always #5 clk = ~clk;

  hazard_fwd_unit #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .src1(src1), .src2(src2), .uses1(uses1), .uses2(uses2),
    .RegWrt_D(RegWrt_D), .write_reg_D(write_reg_D), .is_load_D(is_load_D),
    .flush(flush), .freeze(freeze),
    .EXFWD1_D(exf1), .EXFWD2_D(exf2), .MEMFWD1_D(mf1), .MEMFWD2_D(mf2),
    .stall(stall), .SendNOP_In(nop), .stall_count(cnt)
  );

  hazard_fwd_unit #(.CNT_W(4)) dut_s (
    .clk(clk), .rst(rst), .src1(src1), .src2(src2), .uses1(uses1), .uses2(uses2),
    .RegWrt_D(RegWrt_D), .write_reg_D(write_reg_D), .is_load_D(is_load_D),
    .flush(flush), .freeze(freeze),
    .EXFWD1_D(exf1_s), .EXFWD2_D(exf2_s), .MEMFWD1_D(mf1_s), .MEMFWD2_D(mf2_s),
    .stall(stall_s), .SendNOP_In(nop_s), .stall_count(cnt_s)
  );

  // Expected vector: {exf1,exf2,mf1,mf2,stall,nop,cnt16,cnt4}
  localparam int W = 26;
  logic [W-1:0] exp_q[$];
  string        tag_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: in-flight producers, youngest first (index 0 = EX).
  typedef struct {bit v; bit [2:0] r; bit ld;} instr_t;
  instr_t inflight[$];
  int m_cnt;
  int m_cnt_s;

  function automatic logic [W-1:0] actual();
    logic [5:0] f;
    f = {exf1, exf2, mf1, mf2, stall, nop};
    // The small instance must agree on every flag; fold any difference in.
    if ({exf1_s, exf2_s, mf1_s, mf2_s, stall_s, nop_s} !== f) f = ~f;
    return {f, cnt, cnt_s};
  endfunction

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e, a;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      a = actual();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s: got flags=%b cnt=%0d cnt4=%0d, expected flags=%b cnt=%0d cnt4=%0d",
                 t, a[25:20], a[19:4], a[3:0], e[25:20], e[19:4], e[3:0]);
      end
    end
  end

  function automatic int youngest(input logic [2:0] s, input logic u);
    if (!u) return -1;
    for (int i = 0; i < inflight.size(); i++)
      if (inflight[i].v && inflight[i].r == s) return i;
    return -1;
  endfunction

  task automatic model_reset();
    inflight.delete();
    inflight.push_back('{v: 1'b0, r: 3'd0, ld: 1'b0});
    inflight.push_back('{v: 1'b0, r: 3'd0, ld: 1'b0});
    m_cnt   = 0;
    m_cnt_s = 0;
  endtask

  // Called at posedge+1; returns at the next posedge+1.
  task automatic drive(input logic [2:0] s1, input logic [2:0] s2,
                       input logic u1, input logic u2, input logic rw,
                       input logic [2:0] wr, input logic ld,
                       input logic fl, input logic fz, input string tag);
    int a1, a2;
    logic lu, bub, stl, e1, e2, m1, m2;
    src1 = s1; src2 = s2; uses1 = u1; uses2 = u2;
    RegWrt_D = rw; write_reg_D = wr; is_load_D = ld; flush = fl; freeze = fz;
    a1  = youngest(s1, u1);
    a2  = youngest(s2, u2);
    lu  = (a1 == 0 || a2 == 0) && inflight[0].ld;
    bub = lu || fl;
    stl = lu && !fl;
    e1  = (a1 == 0) && !inflight[0].ld && !bub;
    e2  = (a2 == 0) && !inflight[0].ld && !bub;
    m1  = (a1 == 1) && !bub;
    m2  = (a2 == 1) && !bub;
    exp_q.push_back({e1, e2, m1, m2, stl, bub, 16'(m_cnt), 4'(m_cnt_s)});
    tag_q.push_back(tag);
    @(posedge clk);
    if (!fz) begin
      if (stl) begin
        m_cnt   = (m_cnt   == 65535) ? 65535 : m_cnt + 1;
        m_cnt_s = (m_cnt_s == 15)    ? 15    : m_cnt_s + 1;
      end
      if (bub) inflight.push_front('{v: 1'b0, r: 3'd0, ld: 1'b0});
      else     inflight.push_front('{v: rw, r: wr, ld: ld});
      void'(inflight.pop_back());
    end
    #1;
  endtask

  task automatic idle(input string tag);
    drive(3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, tag);
  endtask

  initial begin
    rst = 1'b0;
    src1 = '0; src2 = '0; write_reg_D = '0;
    uses1 = 0; uses2 = 0; RegWrt_D = 0; is_load_D = 0; flush = 0; freeze = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    idle("reset_idle");
    idle("reset_idle2");

    // ALU producer: EX forward then MEM forward behind an unrelated producer.
    drive(3'd0, 3'd0, 0, 0, 1, 3'd3, 0, 0, 0, "addi_r3");
    drive(3'd3, 3'd0, 1, 0, 1, 3'd6, 0, 0, 0, "exfwd1");
    drive(3'd3, 3'd0, 1, 0, 0, 3'd0, 0, 0, 0, "memfwd1");

    // Load-use on src2.
    drive(3'd0, 3'd0, 0, 0, 1, 3'd1, 1, 0, 0, "ld_r1");
    drive(3'd0, 3'd1, 0, 1, 1, 3'd2, 0, 0, 0, "lu_stall");
    drive(3'd0, 3'd1, 0, 1, 1, 3'd2, 0, 0, 0, "lu_resolve");

    // Same register in EX and MEM, both sources read it.
    drive(3'd0, 3'd0, 0, 0, 1, 3'd5, 0, 0, 0, "r5_a");
    drive(3'd0, 3'd0, 0, 0, 1, 3'd5, 0, 0, 0, "r5_b");
    drive(3'd5, 3'd5, 1, 1, 0, 3'd0, 0, 0, 0, "dual_ex");

    // Load-use coincident with flush.
    drive(3'd0, 3'd0, 0, 0, 1, 3'd4, 1, 0, 0, "ld_r4");
    drive(3'd4, 3'd0, 1, 0, 1, 3'd7, 0, 1, 0, "lu_flush");
    drive(3'd4, 3'd0, 1, 0, 0, 3'd0, 0, 0, 0, "after_flush");

    // Freeze over a pending load-use.
    drive(3'd0, 3'd0, 0, 0, 1, 3'd2, 1, 0, 0, "ld_r2");
    for (int i = 0; i < 3; i++)
      drive(3'd2, 3'd0, 1, 0, 1, 3'd3, 0, 0, 1, "frozen_lu");
    drive(3'd2, 3'd0, 1, 0, 1, 3'd3, 0, 0, 0, "thaw_lu");
    drive(3'd2, 3'd0, 1, 0, 1, 3'd3, 0, 0, 0, "thaw_resolve");

    // Non-writing instruction never matches.
    drive(3'd0, 3'd0, 0, 0, 0, 3'd6, 0, 0, 0, "nowrite");
    drive(3'd6, 3'd6, 1, 1, 0, 3'd0, 0, 0, 0, "nowrite_use");

    // Saturate the 4-bit counter instance.
    for (int i = 0; i < 20; i++) begin
      drive(3'd0, 3'd0, 0, 0, 1, 3'd1, 1, 0, 0, "sat_ld");
      drive(3'd1, 3'd0, 1, 0, 0, 3'd0, 0, 0, 0, "sat_use");
    end

    // Randomised traffic.
    for (int i = 0; i < 2000; i++) begin
      drive(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
            1'($urandom_range(0, 2) == 0),
            1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 7) == 0),
            "random");
    end

    // Asynchronous reset mid-operation while an EX forward is live.
    drive(3'd0, 3'd0, 0, 0, 1, 3'd3, 0, 0, 0, "pre_rst");
    src1 = 3'd3; uses1 = 1'b1; RegWrt_D = 1'b0; is_load_D = 1'b0;
    flush = 1'b0; freeze = 1'b0;
    #1 rst = 1'b0;
    #1;
    checks++;
    if ({exf1, exf2, mf1, mf2, stall, nop, cnt, cnt_s} !== '0) begin
      errors++;
      $display("FAIL async_reset: got flags=%b cnt=%0d cnt4=%0d, expected all zero",
               {exf1, exf2, mf1, mf2, stall, nop}, cnt, cnt_s);
    end
    #1 rst = 1'b1;
    model_reset();
    @(posedge clk); #1;
    drive(3'd3, 3'd0, 1, 0, 0, 3'd0, 0, 0, 0, "post_rst");
    idle("tail");

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
